priority_encoder8: RTL and testbench

Registered 8-to-3 priority encoder with active-low request inputs and active-low coded outputs, in the style of a 74x148. Each clock it scans eight request lines and reports the index of the highest-priority asserted line, plus a group-select flag showing whether any line was asserted. It sits between raw active-low request or interrupt lines and downstream logic that needs a compact, registered request code.

---
 rtl/priority_encoder_pkg.sv | 24 ++
 rtl/priority_encoder8_core.sv | 26 ++
 rtl/priority_encoder8.sv | 44 ++++
 tb/tb_priority_encoder8.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared constants and the reference active-low encoding for the 8-line
// priority encoder.
package priority_encoder_pkg;

    localparam int N_IN_DEFAULT   = 8;
    localparam int CODE_W_DEFAULT = 3;

    localparam logic [CODE_W_DEFAULT:0] IDLE_CODE = '1;

    // Returns {GS_n, ~index} for the highest-index low request, or IDLE_CODE.
    function automatic logic [CODE_W_DEFAULT:0] encode_req(
        input logic [N_IN_DEFAULT-1:0] req_n
    );
        logic [CODE_W_DEFAULT:0] code;
        code = IDLE_CODE;
        for (int i = N_IN_DEFAULT - 1; i >= 0; i--) begin
            if (!req_n[i] && code[CODE_W_DEFAULT]) begin
                code = {1'b0, ~i[CODE_W_DEFAULT-1:0]};
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/priority_encoder8_core.sv
// Combinational MSB-first scan of active-low requests producing the inverted
// winning index and the active-low group-select flag.
module prio_enc_core
    import priority_encoder_pkg::*;
#(
    parameter  int N_IN   = N_IN_DEFAULT,
    localparam int CODE_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]   req_n,
    output logic [CODE_W-1:0] idx_n,
    output logic              gs_n
);

    always_comb begin
        idx_n = '1;
        gs_n  = 1'b1;
        // gs_n doubles as "nothing found yet", so the first hit from the top wins.
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (!req_n[i] && gs_n) begin
                idx_n = ~i[CODE_W-1:0];
                gs_n  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/priority_encoder8.sv
// Registered 74x148-style priority encoder: active-low requests in,
// active-low {GS_n, ~index} out one cycle later.
module priority_encoder8
    import priority_encoder_pkg::*;
#(
    parameter  int N_IN   = N_IN_DEFAULT,
    localparam int CODE_W = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   in,
    output logic [CODE_W:0]   yn
);

    generate
        if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
            $error("priority_encoder8: N_IN must be a power of two >= 2");
        end
    endgenerate

    logic [CODE_W-1:0] idx_n_p0;
    logic              gs_n_p0;
    logic [CODE_W:0]   yn_p1;

    prio_enc_core #(
        .N_IN (N_IN)
    ) u_core (
        .req_n (in),
        .idx_n (idx_n_p0),
        .gs_n  (gs_n_p0)
    );

    // p0 -> p1: output register, forced to the idle code while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yn_p1 <= '1;
        end else begin
            yn_p1 <= {gs_n_p0, idx_n_p0};
        end
    end

    assign yn = yn_p1;

endmodule

// File: tb/tb_priority_encoder8.sv
// Directed bench for priority_encoder8 with hand-computed expected codes.
module tb_priority_encoder8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [3:0] yn;

    int n_cmp;
    int n_bad;

    priority_encoder8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (req),
        .yn    (yn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b1;
        req   = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (yn !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_async: yn=%b required %b", yn, 4'b1111);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (yn !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_held: yn=%b required %b", yn, 4'b1111);
        end
        @(negedge clk);
        req   = 8'hFF;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (yn !== 4'b1111) begin
            n_bad++;
            $display("FAIL reset_release_idle: yn=%b required %b", yn, 4'b1111);
        end
    endtask

    task automatic test_dominate();
        logic [7:0] vin [4] = '{8'b00000000, 8'b01000001, 8'b00000011, 8'b00001011};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req = vin[k];
            @(posedge clk);
            #1;
            n_cmp++;
            if (yn !== 4'b0000) begin
                n_bad++;
                $display("FAIL dominate[%0d] in=%b: yn=%b required %b", k, vin[k], yn, 4'b0000);
            end
        end
    endtask

    task automatic test_masking();
        logic [7:0] vin [2] = '{8'b10100000, 8'b11011111};
        logic [3:0] vex [2] = '{4'b0001, 4'b0010};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req = vin[k];
            @(posedge clk);
            #1;
            n_cmp++;
            if (yn !== vex[k]) begin
                n_bad++;
                $display("FAIL masking[%0d] in=%b: yn=%b required %b", k, vin[k], yn, vex[k]);
            end
        end
    endtask

    task automatic test_walk();
        logic [7:0] vin [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        logic [3:0] vex [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
                                4'b0100, 4'b0101, 4'b0110, 4'b0111};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req = vin[k];
            @(posedge clk);
            #1;
            n_cmp++;
            if (yn !== vex[k]) begin
                n_bad++;
                $display("FAIL walk_line%0d in=%b: yn=%b required %b", 7 - k, vin[k], yn, vex[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vin [4] = '{8'hFF, 8'hFE, 8'h7F, 8'hFF};
        logic [3:0] vex [4] = '{4'b1111, 4'b0111, 4'b0000, 4'b1111};
        logic [3:0] prev;
        @(negedge clk);
        req = 8'h00;
        @(posedge clk);
        prev = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req = vin[k];
            #1;
            n_cmp++;
            if (yn !== prev) begin
                n_bad++;
                $display("FAIL b2b_hold[%0d]: yn=%b required %b", k, yn, prev);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (yn !== vex[k]) begin
                n_bad++;
                $display("FAIL b2b_result[%0d] in=%h: yn=%b required %b", k, vin[k], yn, vex[k]);
            end
            prev = vex[k];
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        req = 8'h00;
        @(posedge clk);
        #1;
        n_cmp++;
        if (yn !== 4'b0000) begin
            n_bad++;
            $display("FAIL midreset_before: yn=%b required %b", yn, 4'b0000);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (yn !== 4'b1111) begin
            n_bad++;
            $display("FAIL midreset_async: yn=%b required %b", yn, 4'b1111);
        end
        #1 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (yn !== 4'b1111) begin
            n_bad++;
            $display("FAIL midreset_released_noedge: yn=%b required %b", yn, 4'b1111);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (yn !== 4'b0000) begin
            n_bad++;
            $display("FAIL midreset_recover: yn=%b required %b", yn, 4'b0000);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        req   = 8'hFF;
        test_reset();
        test_dominate();
        test_masking();
        test_walk();
        test_back_to_back();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
